// File: rtl/pc_source_sel_reg.sv
//----------------------------------------------------------------------------
// Module : pc_source_sel_reg
// Brief  : NUM_SRC-way next-PC selector fused with the PC register, with a
//          one-deep redirect buffer for stalls. Optional macro PC_ALIGN_CHK_EN
//          enables dropping of misaligned targets and the misalign flag.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module pc_source_sel_reg #(
  parameter int              WIDTH    = 32,
  parameter int              NUM_SRC  = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int             SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond,
  input  logic                     stall,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         pc_next,
  output logic                     pending,
  output logic                     sel_err,
  output logic                     misalign
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nx;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_pend_nx;
  logic             r_sel_err;
  logic [WIDTH-1:0] w_src [NUM_SRC];
  logic [WIDTH-1:0] w_pc_next;
  logic             w_req;
  logic             w_legal;
  logic             w_aligned;
  logic             w_go;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src[gi] = src_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Explicit compare loop keeps illegal selects at 0 instead of indexing out of range
  always_comb begin
    w_pc_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == i) w_pc_next = w_src[i];
    end
  end

  assign w_req   = pc_write | (pc_write_cond & cond);
  assign w_legal = (32'(sel) < NUM_SRC);

`ifdef PC_ALIGN_CHK_EN
  logic r_misalign;
  logic w_mis_set;

  assign w_aligned = (w_pc_next[1:0] == 2'b00);
  assign w_mis_set = w_req & w_legal & ~w_aligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_misalign <= 1'b0;
    else          r_misalign <= w_mis_set | (r_misalign & ~err_clr);
  end

  assign misalign = r_misalign;
`else
  assign w_aligned = 1'b1;
  assign misalign  = 1'b0;
`endif

  assign w_go = w_req & w_legal & w_aligned;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_pend_nx  = r_pend;
    case (r_state)
      ST_RUN: begin
        if (w_go) begin
          if (stall) begin
            w_pend_nx  = w_pc_next;
            w_state_nx = ST_HOLD;
          end else begin
            w_pc_nx = w_pc_next;
          end
        end
      end
      ST_HOLD: begin
        if (stall) begin
          if (w_go) w_pend_nx = w_pc_next;
        end else begin
          // a fresh redirect on the release cycle supersedes the buffered one
          w_pc_nx    = w_go ? w_pc_next : r_pend;
          w_state_nx = ST_RUN;
        end
      end
      default: w_state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_pend    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_pend    <= w_pend_nx;
      r_sel_err <= (w_req & ~w_legal) | (r_sel_err & ~err_clr);
    end
  end

  assign pc      = r_pc;
  assign pc_next = w_pc_next;
  assign pending = (r_state == ST_HOLD);
  assign sel_err = r_sel_err;

endmodule

`default_nettype wire
